cpu_clken_generator: RTL and testbench
======================================

# cpu_clken_generator

Parametrised, single-clock successor to the BUFGMUX-based CPU clock selector. It derives CPU clock-enable pulses from the master clock instead of muxing divided clocks. Speed changes are applied only at a common phase boundary, so they are glitch-free. Contention suppresses ticks cycle-exactly, and a T-state/frame counter runs on the delivered ticks. It sits between the master-clock PLL output and the CPU/ULA timing logic. All consumers stay on `clk` and qualify with the enables.

## Interface
Parameters:
- `NUM_SPEEDS`, 4: number of speed modes, ≥2. Speed s has a tick period of 2^(NUM_SPEEDS-1-s) `clk` cycles: 0 is slowest, NUM_SPEEDS-1 ticks every cycle.
- `SEL_W`, 2: width of speed select, ≥ clog2(NUM_SPEEDS).
- `RESET_SPEED`, 0: speed in force after reset.
- `FRAME_TSTATES`, 69888: T-states per frame, ≥2.
- `TSTATE_W`, 17: T-state counter width, with 2^TSTATE_W ≥ FRAME_TSTATES.

Ports:
- `clk`, in, 1: master clock (28 MHz nominal).
- `rst`, in, 1: reset. Synchronous and active-high.
- `speed_sel`, in, SEL_W: requested speed. Values ≥NUM_SPEEDS are clamped to NUM_SPEEDS-1.
- `contention`, in, 1: when high, suppresses the CPU tick in that cycle.
- `cpu_clken`, out, 1: CPU tick, gated by contention.
- `cpu_clken_plain`, out, 1: CPU tick, ignoring contention.
- `speed_clken`, out, NUM_SPEEDS: free-running tick for every speed; bit s is speed s.
- `speed_cur`, out, SEL_W: speed currently in force.
- `switch_busy`, out, 1: a requested speed differs from `speed_cur` and has not yet been committed.
- `tstate`, out, TSTATE_W: T-state count within the frame.
- `frame_pulse`, out, 1: one-cycle pulse on frame wrap.

## Operation
- Divider: `cnt` is CW = NUM_SPEEDS-1 bits wide. It increments every cycle and wraps from all-ones to 0.
- Raw tick for speed s:
  - Let L_s = CW-s.
  - raw[s] = AND of cnt[L_s-1:0].
  - raw[NUM_SPEEDS-1] = 1.
  - At cnt = all-ones, every raw[s] = 1. This is the commit boundary.
- Request tracking:
  - Every cycle, `pending` <= clamp(speed_sel). The latest request wins.
  - `switch_busy` <= (clamp(speed_sel) != speed_cur after this edge).
- Commit: in the boundary cycle, `speed_cur` <= pending.
  - The boundary-cycle tick is produced under the old speed. Because both speeds tick there, no short or doubled tick can occur.
  - The new period counts from cnt = 0.
- A request that returns to `speed_cur` before the boundary commits nothing and clears `switch_busy`.
- Registered outputs, computed from current-cycle values:
  - `speed_clken[s]` <= raw[s].
  - `cpu_clken_plain` <= raw[speed_cur].
  - `cpu_clken` <= raw[speed_cur] & ~contention.
- A suppressed tick is dropped, not deferred. The next tick occurs at the next divider phase, which preserves ULA alignment.
- T-state counter: on each cycle where raw[speed_cur] & ~contention, `tstate` advances.
  - If tstate = FRAME_TSTATES-1, it wraps to 0 and `frame_pulse` <= 1.
  - Otherwise it increments by 1 and `frame_pulse` <= 0.
  - In all other cycles, `frame_pulse` <= 0.
- Reset (has priority over all other activity):
  - cnt = 0; speed_cur = pending = RESET_SPEED.
  - All enables 0; switch_busy = 0; tstate = 0; frame_pulse = 0.

## Timing
- Output latency: 1 cycle from `cnt`, `contention` and `speed_sel` to every output.
- `tstate` changes on the same edge that raises `cpu_clken`, so it already shows the new count while `cpu_clken` = 1.
- Duty cycle: the top speed (s = NUM_SPEEDS-1) has `cpu_clken` constantly 1 unless contended. Every other speed has a 1-cycle pulse per period.
- Commit latency: a request sampled at cnt = k commits at the edge ending the next cnt = all-ones cycle, i.e. within 2^CW - k cycles. `speed_cur` changes 1 cycle after that boundary cycle.
- Contention and commit in the same cycle:
  - The commit still occurs.
  - The tick is suppressed.
  - `cpu_clken_plain` still pulses.
- Releasing `rst` mid-operation: counting resumes with cnt = 0, so the first `speed_clken[0]` occurs in the 2^CW-th cycle after the last reset cycle.

## Test plan
- Reset values, NUM_SPEEDS=4, RESET_SPEED=0, speed_sel=0:
  - During `rst`: all outputs 0 and speed_cur = 0.
  - After release: cpu_clken pulses once every 8 cycles, first at cycle 8; tstate increments with each pulse.
- Speed switch 0→3 requested at cnt = 2:
  - switch_busy = 1 from the next cycle.
  - speed_cur = 3 after the cnt = 7 boundary.
  - cpu_clken is continuously 1 afterwards.
  - No tick interval is shorter than 1 or longer than 8.
- Request bounce: speed_sel goes 0→2→0 before the boundary → speed_cur stays 0, switch_busy returns to 0, and the tick pattern is unchanged.
- Contention: at speed 1 (period 4), hold contention high for 6 cycles covering 2 ticks:
  - Both ticks are dropped from cpu_clken.
  - cpu_clken_plain still pulses.
  - tstate advances by 0 during that window.
- Frame wrap: FRAME_TSTATES=10 at speed 3 → tstate counts 0..9 then 0, and frame_pulse is high for exactly 1 cycle at each wrap, every 10 cycles.
- Clamp: speed_sel = 3 with NUM_SPEEDS=3, SEL_W=2 → speed_cur = 2. Asserting rst mid-frame returns tstate to 0 and speed_cur to RESET_SPEED on the next edge.

Source files
------------

// File: rtl/cpu_clken_generator.sv
// cpu_clken_generator: derives CPU clock-enable pulses from the master clock.
// A free-running binary divider supplies one tick phase per speed mode. Speed
// changes commit only when every phase ticks together (divider all-ones), so
// the CPU never sees a short or doubled tick. Contention drops ticks without
// deferring them, and a T-state/frame counter advances on delivered ticks.
module cpu_clken_generator #(
    parameter int NUM_SPEEDS    = 4,
    parameter int SEL_W         = 2,
    parameter int RESET_SPEED   = 0,
    parameter int FRAME_TSTATES = 69888,
    parameter int TSTATE_W      = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_W-1:0]      speed_sel,
    input  logic                  contention,
    output logic                  cpu_clken,
    output logic                  cpu_clken_plain,
    output logic [NUM_SPEEDS-1:0] speed_clken,
    output logic [SEL_W-1:0]      speed_cur,
    output logic                  switch_busy,
    output logic [TSTATE_W-1:0]   tstate,
    output logic                  frame_pulse
);

    localparam int                 CW        = NUM_SPEEDS - 1;
    localparam logic [SEL_W-1:0]    MAX_SPEED = SEL_W'(NUM_SPEEDS - 1);
    localparam logic [SEL_W-1:0]    RST_SPEED = SEL_W'(RESET_SPEED);
    localparam logic [TSTATE_W-1:0] LAST_TS   = TSTATE_W'(FRAME_TSTATES - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SEL_W-1:0]      pending_q, pending_d;
    logic [SEL_W-1:0]      speed_cur_q, speed_cur_d;
    logic                  switch_busy_q, switch_busy_d;
    logic [NUM_SPEEDS-1:0] speed_clken_q, speed_clken_d;
    logic                  cpu_clken_plain_q, cpu_clken_plain_d;
    logic                  cpu_clken_q, cpu_clken_d;
    logic [TSTATE_W-1:0]   tstate_q, tstate_d;
    logic                  frame_pulse_q, frame_pulse_d;

    logic [NUM_SPEEDS-1:0] raw;
    logic [SEL_W-1:0]      sel_clamped;
    logic                  cur_raw;
    logic                  boundary;

    // Raw tick per speed: speed s ticks when the low CW-s divider bits are all
    // ones; the top speed has an empty mask and so ticks every cycle.
    always_comb begin
        raw = '0;
        for (int s = 0; s < NUM_SPEEDS; s++) begin
            raw[s] = &(cnt_q | ~CW'((1 << (CW - s)) - 1));
        end
    end

    // Next-state logic: divider, request tracking, commit, enables, T-states.
    always_comb begin
        sel_clamped = (speed_sel > MAX_SPEED) ? MAX_SPEED : speed_sel;
        boundary    = &cnt_q;

        cur_raw = 1'b0;
        for (int s = 0; s < NUM_SPEEDS; s++) begin
            if (speed_cur_q == SEL_W'(s)) cur_raw = raw[s];
        end

        cnt_d     = cnt_q + CW'(1);
        pending_d = sel_clamped;
        // Commit only where old and new speeds both tick; the boundary tick
        // itself is still issued under the old speed.
        speed_cur_d   = boundary ? pending_q : speed_cur_q;
        switch_busy_d = (sel_clamped != speed_cur_d);

        speed_clken_d     = raw;
        cpu_clken_plain_d = cur_raw;
        cpu_clken_d       = cur_raw & ~contention;

        // Count only delivered ticks so tstate stays in step with cpu_clken.
        tstate_d      = tstate_q;
        frame_pulse_d = 1'b0;
        if (cpu_clken_d) begin
            if (tstate_q == LAST_TS) begin
                tstate_d      = '0;
                frame_pulse_d = 1'b1;
            end else begin
                tstate_d = tstate_q + TSTATE_W'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q             <= '0;
            pending_q         <= RST_SPEED;
            speed_cur_q       <= RST_SPEED;
            switch_busy_q     <= 1'b0;
            speed_clken_q     <= '0;
            cpu_clken_plain_q <= 1'b0;
            cpu_clken_q       <= 1'b0;
            tstate_q          <= '0;
            frame_pulse_q     <= 1'b0;
        end else begin
            cnt_q             <= cnt_d;
            pending_q         <= pending_d;
            speed_cur_q       <= speed_cur_d;
            switch_busy_q     <= switch_busy_d;
            speed_clken_q     <= speed_clken_d;
            cpu_clken_plain_q <= cpu_clken_plain_d;
            cpu_clken_q       <= cpu_clken_d;
            tstate_q          <= tstate_d;
            frame_pulse_q     <= frame_pulse_d;
        end
    end

    assign cpu_clken       = cpu_clken_q;
    assign cpu_clken_plain = cpu_clken_plain_q;
    assign speed_clken     = speed_clken_q;
    assign speed_cur       = speed_cur_q;
    assign switch_busy     = switch_busy_q;
    assign tstate          = tstate_q;
    assign frame_pulse     = frame_pulse_q;

endmodule

// File: tb/tb_cpu_clken_generator.sv
// Bench for cpu_clken_generator: two instances (default 4-speed, and a
// 3-speed / 10-T-state frame variant) compared every cycle against a
// cycle-count based reference model, plus targeted scenario checks.
module tb_cpu_clken_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NUM_SPEEDS=4, default frame
    logic        rst_a, cont_a;
    logic [1:0]  sel_a;
    logic        ck_a, pl_a, busy_a, fp_a;
    logic [3:0]  sck_a;
    logic [1:0]  cur_a;
    logic [16:0] ts_a;

    // Instance B: NUM_SPEEDS=3, FRAME_TSTATES=10
    logic        rst_b, cont_b;
    logic [1:0]  sel_b;
    logic        ck_b, pl_b, busy_b, fp_b;
    logic [2:0]  sck_b;
    logic [1:0]  cur_b;
    logic [3:0]  ts_b;

    cpu_clken_generator u_a (
        .clk(clk), .rst(rst_a), .speed_sel(sel_a), .contention(cont_a),
        .cpu_clken(ck_a), .cpu_clken_plain(pl_a), .speed_clken(sck_a),
        .speed_cur(cur_a), .switch_busy(busy_a), .tstate(ts_a), .frame_pulse(fp_a)
    );

    cpu_clken_generator #(
        .NUM_SPEEDS(3), .SEL_W(2), .RESET_SPEED(0), .FRAME_TSTATES(10), .TSTATE_W(4)
    ) u_b (
        .clk(clk), .rst(rst_b), .speed_sel(sel_b), .contention(cont_b),
        .cpu_clken(ck_b), .cpu_clken_plain(pl_b), .speed_clken(sck_b),
        .speed_cur(cur_b), .switch_busy(busy_b), .tstate(ts_b), .frame_pulse(fp_b)
    );

    logic [26:0] obs_a;
    logic [12:0] obs_b;
    assign obs_a = {ck_a, pl_a, sck_a, cur_a, busy_a, ts_a, fp_a};
    assign obs_b = {ck_b, pl_b, sck_b, cur_b, busy_b, ts_b, fp_b};

    int checks = 0;
    int failures = 0;
    int cyc_no = 0;

    // Reference model: t = cycles since reset release, so divider phase is t mod 2^(N-1).
    int         m_t[2], m_cur[2], m_pend[2], m_ts[2];
    logic       m_ck[2], m_pl[2], m_busy[2], m_fp[2];
    logic [3:0] m_sck[2];

    function automatic int ns(int i); return (i == 0) ? 4 : 3; endfunction
    function automatic int fr(int i); return (i == 0) ? 69888 : 10; endfunction
    function automatic int clampi(int i, int v); return (v >= ns(i)) ? ns(i) - 1 : v; endfunction

    // Speed s ticks on the last cycle of each 2^(N-1-s)-cycle period.
    function automatic logic tick(int i, int s, int t);
        int per, cy;
        per = 1 << (ns(i) - 1 - s);
        cy  = 1 << (ns(i) - 1);
        return ((t % cy) % per) == per - 1;
    endfunction

    task automatic model_edge(int i, logic r, int sel, logic cont);
        int cy, newcur;
        cy = 1 << (ns(i) - 1);
        if (r) begin
            m_t[i] = 0; m_cur[i] = 0; m_pend[i] = 0; m_ts[i] = 0;
            m_ck[i] = 0; m_pl[i] = 0; m_busy[i] = 0; m_fp[i] = 0; m_sck[i] = '0;
        end else begin
            m_pl[i] = tick(i, m_cur[i], m_t[i]);
            m_ck[i] = m_pl[i] & ~cont;
            m_sck[i] = '0;
            for (int s = 0; s < ns(i); s++) m_sck[i][s] = tick(i, s, m_t[i]);
            newcur = ((m_t[i] % cy) == cy - 1) ? m_pend[i] : m_cur[i];
            m_pend[i] = clampi(i, sel);
            m_busy[i] = (clampi(i, sel) != newcur);
            m_cur[i] = newcur;
            m_fp[i] = 1'b0;
            if (m_ck[i]) begin
                if (m_ts[i] == fr(i) - 1) begin m_ts[i] = 0; m_fp[i] = 1'b1; end
                else m_ts[i] = m_ts[i] + 1;
            end
            m_t[i] = m_t[i] + 1;
        end
    endtask

    function automatic logic [26:0] exp_a();
        logic [1:0] c; logic [16:0] t;
        c = 2'(m_cur[0]); t = 17'(m_ts[0]);
        return {m_ck[0], m_pl[0], m_sck[0], c, m_busy[0], t, m_fp[0]};
    endfunction

    function automatic logic [12:0] exp_b();
        logic [1:0] c; logic [3:0] t; logic [3:0] k;
        c = 2'(m_cur[1]); t = 4'(m_ts[1]); k = m_sck[1];
        return {m_ck[1], m_pl[1], k[2:0], c, m_busy[1], t, m_fp[1]};
    endfunction

    // One clock: update model at the edge, then settle before sampling.
    task automatic cyc();
        @(posedge clk);
        model_edge(0, rst_a, int'(sel_a), cont_a);
        model_edge(1, rst_b, int'(sel_b), cont_b);
        cyc_no++;
        #1;
    endtask

    task automatic test_reset();
        int first;
        rst_a = 1; rst_b = 1; sel_a = 0; sel_b = 0; cont_a = 0; cont_b = 0;
        repeat (3) cyc();
        checks++;
        if (obs_a !== 27'd0) begin failures++; $display("FAIL reset_a got=%h want=0", obs_a); end
        checks++;
        if (obs_b !== 13'd0) begin failures++; $display("FAIL reset_b got=%h want=0", obs_b); end
        rst_a = 0; rst_b = 0;
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            checks++;
            if (obs_a !== exp_a()) begin failures++; $display("FAIL reset_model_a got=%h want=%h", obs_a, exp_a()); end
            checks++;
            if (obs_b !== exp_b()) begin failures++; $display("FAIL reset_model_b got=%h want=%h", obs_b, exp_b()); end
            if (ck_a === 1'b1 && first < 0) first = k;
        end
        checks++;
        if (first !== 8) begin failures++; $display("FAIL first_tick got=%0d want=8", first); end
        checks++;
        if (ts_a !== 17'd2) begin failures++; $display("FAIL reset_tstate got=%0d want=2", ts_a); end
    endtask

    task automatic test_switch();
        int n, last, bad, high;
        last = -1; bad = 0; high = 0;
        for (int k = 0; k < 16 && (m_t[0] % 8) != 2; k++) cyc();
        sel_a = 3;
        cyc();
        checks++;
        if (busy_a !== 1'b1) begin failures++; $display("FAIL switch_busy_set got=%b want=1", busy_a); end
        n = 0;
        while (cur_a !== 2'd3 && n < 20) begin
            cyc(); n++;
            checks++;
            if (obs_a !== exp_a()) begin failures++; $display("FAIL switch_model got=%h want=%h", obs_a, exp_a()); end
            if (ck_a === 1'b1) begin
                if (last >= 0 && (cyc_no - last < 1 || cyc_no - last > 8)) bad++;
                last = cyc_no;
            end
        end
        checks++;
        if (n !== 5) begin failures++; $display("FAIL switch_commit_latency got=%0d want=5", n); end
        for (int k = 0; k < 10; k++) begin
            cyc();
            checks++;
            if (obs_a !== exp_a()) begin failures++; $display("FAIL switch_fast_model got=%h want=%h", obs_a, exp_a()); end
            if (ck_a === 1'b1) begin
                high++;
                if (last >= 0 && (cyc_no - last < 1 || cyc_no - last > 8)) bad++;
                last = cyc_no;
            end
        end
        checks++;
        if (high !== 10) begin failures++; $display("FAIL switch_continuous got=%0d want=10", high); end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL switch_interval bad_gaps=%0d want=0", bad); end
    endtask

    task automatic test_bounce();
        int n, ticks;
        sel_a = 0; n = 0;
        while (cur_a !== 2'd0 && n < 20) begin cyc(); n++; end
        for (int k = 0; k < 16 && (m_t[0] % 8) != 1; k++) cyc();
        sel_a = 2;
        cyc();
        checks++;
        if (busy_a !== 1'b1) begin failures++; $display("FAIL bounce_busy_set got=%b want=1", busy_a); end
        sel_a = 0;
        cyc();
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL bounce_busy_clear got=%b want=0", busy_a); end
        ticks = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            checks++;
            if (obs_a !== exp_a() || cur_a !== 2'd0) begin
                failures++; $display("FAIL bounce_model got=%h want=%h", obs_a, exp_a());
            end
            if (ck_a === 1'b1) ticks++;
        end
        checks++;
        if (ticks !== 1) begin failures++; $display("FAIL bounce_ticks got=%0d want=1", ticks); end
    endtask

    task automatic test_contention();
        int n, nck, npl;
        logic [16:0] saved;
        sel_a = 1; n = 0;
        while (cur_a !== 2'd1 && n < 20) begin cyc(); n++; end
        for (int k = 0; k < 8 && (m_t[0] % 4) != 2; k++) cyc();
        saved = ts_a; nck = 0; npl = 0;
        cont_a = 1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            checks++;
            if (obs_a !== exp_a()) begin failures++; $display("FAIL cont_model got=%h want=%h", obs_a, exp_a()); end
            nck += int'(ck_a); npl += int'(pl_a);
        end
        cont_a = 0;
        checks++;
        if (nck !== 0) begin failures++; $display("FAIL cont_clken got=%0d want=0", nck); end
        checks++;
        if (npl !== 2) begin failures++; $display("FAIL cont_plain got=%0d want=2", npl); end
        checks++;
        if (ts_a !== saved) begin failures++; $display("FAIL cont_tstate got=%0d want=%0d", ts_a, saved); end
    endtask

    task automatic test_frame();
        int n, last, pulses;
        sel_b = 3; n = 0;
        while (cur_b !== 2'd2 && n < 10) begin cyc(); n++; end
        checks++;
        if (cur_b !== 2'd2) begin failures++; $display("FAIL clamp_speed got=%0d want=2", cur_b); end
        last = -1; pulses = 0;
        for (int k = 0; k < 35; k++) begin
            cyc();
            checks++;
            if (obs_b !== exp_b()) begin failures++; $display("FAIL frame_model got=%h want=%h", obs_b, exp_b()); end
            if (fp_b === 1'b1) begin
                pulses++;
                checks++;
                if (ts_b !== 4'd0 || (last >= 0 && cyc_no - last != 10)) begin
                    failures++; $display("FAIL frame_wrap tstate=%0d gap=%0d want 0/10", ts_b, cyc_no - last);
                end
                last = cyc_no;
            end
        end
        checks++;
        if (pulses < 3) begin failures++; $display("FAIL frame_pulses got=%0d want>=3", pulses); end
    endtask

    task automatic test_rst_mid();
        for (int k = 0; k < 12 && ts_b == 4'd0; k++) cyc();
        rst_a = 1; rst_b = 1;
        cyc();
        checks++;
        if (ts_b !== 4'd0 || cur_b !== 2'd0) begin
            failures++; $display("FAIL rst_mid_b tstate=%0d cur=%0d want 0/0", ts_b, cur_b);
        end
        checks++;
        if (ts_a !== 17'd0 || cur_a !== 2'd0) begin
            failures++; $display("FAIL rst_mid_a tstate=%0d cur=%0d want 0/0", ts_a, cur_a);
        end
        rst_a = 0; rst_b = 0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0) sel_a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) sel_b = 2'($urandom_range(0, 3));
            cont_a = ($urandom_range(0, 3) == 0);
            cont_b = ($urandom_range(0, 3) == 0);
            rst_a  = ($urandom_range(0, 99) == 0);
            rst_b  = ($urandom_range(0, 99) == 0);
            cyc();
            checks++;
            if (obs_a !== exp_a()) begin failures++; $display("FAIL random_a got=%h want=%h", obs_a, exp_a()); end
            checks++;
            if (obs_b !== exp_b()) begin failures++; $display("FAIL random_b got=%h want=%h", obs_b, exp_b()); end
        end
        rst_a = 0; rst_b = 0; cont_a = 0; cont_b = 0;
    endtask

    initial begin
        test_reset();
        test_switch();
        test_bounce();
        test_contention();
        test_frame();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
